// File: rtl/updown10_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : updown10_ctrl
// Purpose  : Prescaled run controller for a 0-9 up/down counter (EN/DEC).
//            Define UPDOWN10_CTRL_SYNC_EN to synchronise and edge-detect
//            the START/STOP inputs.
// Revision : 1.0 - initial release
// ============================================================================
module updown10_ctrl #(
  parameter int SEC1_MAX = 50_000_000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic       STOP,
  input  logic [1:0] MODE,
  input  logic       DIR,
  input  logic [3:0] COUNT,
  output logic       EN,
  output logic       DEC,
  output logic       BUSY,
  output logic       DONE,
  output logic [1:0] STATE
);

  localparam int             c_PW       = (SEC1_MAX > 1) ? $clog2(SEC1_MAX) : 1;
  localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(SEC1_MAX - 1);

  localparam logic [1:0] c_IDLE  = 2'b00;
  localparam logic [1:0] c_RUN   = 2'b01;
  localparam logic [1:0] c_PAUSE = 2'b10;
  localparam logic [1:0] c_FIN   = 2'b11;

  localparam logic [1:0] c_M_UP     = 2'b00;
  localparam logic [1:0] c_M_DOWN   = 2'b01;
  localparam logic [1:0] c_M_BOUNCE = 2'b10;

  logic w_start;
  logic w_stop;

`ifdef UPDOWN10_CTRL_SYNC_EN
  // Two sync flops, one history flop, then a registered rising-edge pulse.
  logic [2:0] r_start_sh;
  logic [2:0] r_stop_sh;
  logic       r_start_req;
  logic       r_stop_req;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_start_sh  <= 3'b000;
      r_stop_sh   <= 3'b000;
      r_start_req <= 1'b0;
      r_stop_req  <= 1'b0;
    end else begin
      r_start_sh  <= {r_start_sh[1:0], START};
      r_stop_sh   <= {r_stop_sh[1:0], STOP};
      r_start_req <= r_start_sh[1] & ~r_start_sh[2];
      r_stop_req  <= r_stop_sh[1] & ~r_stop_sh[2];
    end
  end

  assign w_start = r_start_req;
  assign w_stop  = r_stop_req;
`else
  assign w_start = START;
  assign w_stop  = STOP;
`endif

  logic [1:0]      r_state;
  logic [c_PW-1:0] r_pre;
  logic [1:0]      r_mode;
  logic            r_dir;
  logic            r_en;

  logic w_tick;
  logic w_at9;
  logic w_at0;

  assign w_tick = (r_pre == c_PRE_LAST);
  assign w_at9  = (COUNT == 4'd9);
  assign w_at0  = (COUNT == 4'd0);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= c_IDLE;
      r_pre   <= '0;
      r_mode  <= 2'b00;
      r_dir   <= 1'b0;
      r_en    <= 1'b0;
    end else begin
      r_en <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_start && !w_stop) begin
            r_state <= c_RUN;
            r_pre   <= '0;
            r_mode  <= MODE;
            r_dir   <= (MODE == c_M_UP) ? 1'b0 : ((MODE == c_M_DOWN) ? 1'b1 : DIR);
          end
        end
        c_RUN: begin
          if (w_stop) begin
            r_state <= c_PAUSE;
          end else if (!w_tick) begin
            r_pre <= r_pre + 1'b1;
          end else begin
            r_pre <= '0;
            case (r_mode)
              c_M_UP: begin
                if (w_at9) r_state <= c_FIN;
                else       r_en    <= 1'b1;
              end
              c_M_DOWN: begin
                if (w_at0) r_state <= c_FIN;
                else       r_en    <= 1'b1;
              end
              c_M_BOUNCE: begin
                // The flip and the EN leaving the boundary share one edge.
                r_en <= 1'b1;
                if (!r_dir && w_at9)     r_dir <= 1'b1;
                else if (r_dir && w_at0) r_dir <= 1'b0;
              end
              default: r_en <= 1'b1;
            endcase
          end
        end
        c_PAUSE: begin
          if (w_stop)       r_state <= c_IDLE;
          else if (w_start) r_state <= c_RUN;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign EN    = r_en;
  assign DEC   = r_dir;
  assign STATE = r_state;
  assign BUSY  = (r_state == c_RUN) || (r_state == c_PAUSE);
  assign DONE  = (r_state == c_FIN);

endmodule
`default_nettype wire

// File: tb/tb_updown10_ctrl.sv
`default_nettype none
// Bench for updown10_ctrl: directed up-once run plus randomized traffic checked
// against a behavioural model with an attached 0-9 counter.
module tb_updown10_ctrl;

  localparam int SEC1_MAX = 4;
`ifdef UPDOWN10_CTRL_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 0;
`endif

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_FIN   = 3;

  logic       CLK   = 1'b0;
  logic       RESET = 1'b1;
  logic       START = 1'b0;
  logic       STOP  = 1'b0;
  logic [1:0] MODE  = 2'b00;
  logic       DIR   = 1'b0;
  logic [3:0] COUNT = 4'd0;
  logic       EN;
  logic       DEC;
  logic       BUSY;
  logic       DONE;
  logic [1:0] STATE;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: run state, cycles left before the next tick decision,
  // direction, latched mode, expected EN, and the attached counter value.
  int m_st   = S_IDLE;
  int m_left = 0;
  int m_mode = 0;
  bit m_down = 1'b0;
  bit m_en   = 1'b0;
  int m_cnt  = 0;
  bit [4:0] h_start = '0;
  bit [4:0] h_stop  = '0;

  always #5 CLK = ~CLK;

  updown10_ctrl #(.SEC1_MAX(SEC1_MAX)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .START (START),
    .STOP  (STOP),
    .MODE  (MODE),
    .DIR   (DIR),
    .COUNT (COUNT),
    .EN    (EN),
    .DEC   (DEC),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .STATE (STATE)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st    = S_IDLE;
    m_left  = 0;
    m_mode  = 0;
    m_down  = 1'b0;
    m_en    = 1'b0;
    h_start = '0;
    h_stop  = '0;
  endtask

  task automatic model_step(input bit s, input bit p);
    bit en_old;
    bit dn_old;
    bit go;
    bit halt;
    bit at_top;
    bit at_bot;
    en_old = m_en;
    dn_old = m_down;
`ifdef UPDOWN10_CTRL_SYNC_EN
    h_start = {h_start[3:0], s};
    h_stop  = {h_stop[3:0], p};
    go   = h_start[3] & ~h_start[4];
    halt = h_stop[3] & ~h_stop[4];
`else
    go   = s;
    halt = p;
`endif
    at_top = (m_cnt == 9);
    at_bot = (m_cnt == 0);
    m_en = 1'b0;
    case (m_st)
      S_IDLE: begin
        if (go && !halt) begin
          m_st   = S_RUN;
          m_left = SEC1_MAX - 1;
          m_mode = int'(MODE);
          m_down = (m_mode == 1) ? 1'b1 : ((m_mode == 0) ? 1'b0 : DIR);
        end
      end
      S_RUN: begin
        if (halt) m_st = S_PAUSE;
        else if (m_left > 0) m_left--;
        else begin
          m_left = SEC1_MAX - 1;
          if ((m_mode == 0 && at_top) || (m_mode == 1 && at_bot)) m_st = S_FIN;
          else begin
            if (m_mode == 2 && (m_down ? at_bot : at_top)) m_down = !m_down;
            m_en = 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (halt)    m_st = S_IDLE;
        else if (go) m_st = S_RUN;
      end
      default: m_st = S_IDLE;
    endcase
    // Attached counter reacts to the EN/DEC present during this cycle.
    if (en_old) begin
      if (dn_old) m_cnt = (m_cnt == 0) ? 9 : m_cnt - 1;
      else        m_cnt = (m_cnt == 9) ? 0 : (m_cnt + 1) % 16;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge after checking.
  task automatic cycle(input bit s, input bit p);
    START = s;
    STOP  = p;
    COUNT = 4'(m_cnt);
    @(posedge CLK);
    model_step(s, p);
    @(negedge CLK);
    check("EN", {7'd0, EN}, {7'd0, m_en});
    check("DEC", {7'd0, DEC}, {7'd0, m_down});
    check("STATE", {6'd0, STATE}, 8'(m_st));
    check("BUSY", {7'd0, BUSY}, {7'd0, (m_st == S_RUN || m_st == S_PAUSE)});
    check("DONE", {7'd0, DONE}, {7'd0, (m_st == S_FIN)});
  endtask

  initial begin
    int en_q[$];
    int done_cyc;
    int busy_rise;
    int busy_rises;
    bit prev_busy;
    bit s;
    bit p;

    repeat (2) @(negedge CLK);
    check("rst_EN", {7'd0, EN}, 8'd0);
    check("rst_DEC", {7'd0, DEC}, 8'd0);
    check("rst_STATE", {6'd0, STATE}, 8'd0);
    check("rst_BUSY", {7'd0, BUSY}, 8'd0);
    check("rst_DONE", {7'd0, DONE}, 8'd0);
    RESET = 1'b0;
    model_reset();

    // Directed up-once run from COUNT=7; cycle 0 is the START cycle.
    m_cnt      = 7;
    MODE       = 2'b00;
    DIR        = 1'b1;
    done_cyc   = -1;
    busy_rise  = -1;
    busy_rises = 0;
    prev_busy  = 1'b0;
    for (int k = 0; k < 24; k++) begin
      cycle((LAT != 0) ? (k < 10) : (k == 0), 1'b0);
      if (EN === 1'b1) en_q.push_back(k + 1);
      if (DONE === 1'b1) done_cyc = k + 1;
      if (BUSY === 1'b1 && !prev_busy) begin
        busy_rises++;
        if (busy_rise < 0) busy_rise = k + 1;
      end
      prev_busy = (BUSY === 1'b1);
    end
    check("dir_en_count", 8'(en_q.size()), 8'd2);
    check("dir_en1_cycle", (en_q.size() > 0) ? 8'(en_q[0]) : 8'hFF, 8'(5 + LAT));
    check("dir_en2_cycle", (en_q.size() > 1) ? 8'(en_q[1]) : 8'hFF, 8'(9 + LAT));
    check("dir_done_cycle", 8'(done_cyc), 8'(13 + LAT));
    check("dir_busy_rise", 8'(busy_rise), 8'(1 + LAT));
    check("dir_busy_runs", 8'(busy_rises), 8'd1);

    // Randomized traffic with occasional mid-run asynchronous reset.
    for (int i = 0; i < 4000; i++) begin
      MODE = 2'($urandom_range(0, 3));
      DIR  = 1'($urandom_range(0, 1));
      case (m_st)
        S_IDLE: begin
          if (!m_en && $urandom_range(0, 7) == 0) m_cnt = $urandom_range(0, 11);
          s = ($urandom_range(0, 5) == 0);
          p = s ? 1'b0 : ($urandom_range(0, 9) == 0);
        end
        S_RUN: begin
          s = ($urandom_range(0, 9) == 0);
          p = ($urandom_range(0, 24) == 0);
        end
        default: begin
          s = ($urandom_range(0, 5) == 0);
          p = ($urandom_range(0, 11) == 0);
        end
      endcase
      if (m_st == S_RUN && $urandom_range(0, 199) == 0) begin
        START = 1'b0;
        STOP  = 1'b0;
        RESET = 1'b1;
        #1;
        check("arst_EN", {7'd0, EN}, 8'd0);
        check("arst_DEC", {7'd0, DEC}, 8'd0);
        check("arst_STATE", {6'd0, STATE}, 8'd0);
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
      end else begin
        cycle(s, p);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
